thread_sched: RTL

Round-robin thread scheduler for the sha256 engine. It tracks a 2-bit state per thread (IDLE/READY/BUSY) and scans threads in the engine's interleaved core/sequence order. When it finds a READY thread, it issues that thread number to the downstream consumer through a registered valid/accept handshake. It sits directly downstream of the thread-numbering logic: the scan pointer steps through the same next-thread ordering, implemented internally.

---
 rtl/thread_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/thread_sched.sv
// rtl/thread_sched.sv - round-robin READY-thread scheduler with registered issue handshake
module thread_sched #(
    parameter int N_CORES       = 2,
    parameter int N_THREADS     = 4 * N_CORES,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     ready_en,
    input  logic [N_THREADS_MSB:0]   ready_num,
    input  logic                     done_en,
    input  logic [N_THREADS_MSB:0]   done_num,
    input  logic                     out_rd,
    output logic                     out_valid,
    output logic [N_THREADS_MSB:0]   out_num,
    output logic [N_THREADS_MSB+1:0] ready_cnt,
    output logic                     err
);

    localparam int NUM_W  = N_THREADS_MSB + 1;
    localparam int CORE_W = N_THREADS_MSB;
    localparam int CNT_W  = N_THREADS_MSB + 2;
    localparam logic [CORE_W-1:0] CORE_LAST = CORE_W'(2 * N_CORES - 1);
    localparam logic [CNT_W-1:0]  THREAD_LIMIT = CNT_W'(N_THREADS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } tstate_t;

    tstate_t           state [N_THREADS];
    logic [NUM_W-1:0]  ptr;
    logic [NUM_W-1:0]  ptr_next;
    logic              slot_free;
    logic              issue;
    logic              ready_ok;
    logic              done_ok;
    logic              ready_in_range;
    logic              done_in_range;

    // Decisions for this cycle, all taken from registered state
    always_comb begin
        slot_free      = !out_valid || out_rd;
        issue          = slot_free && (state[ptr] == ST_READY);
        ready_in_range = {1'b0, ready_num} < THREAD_LIMIT;
        done_in_range  = {1'b0, done_num} < THREAD_LIMIT;
        ready_ok       = ready_en && ready_in_range && (state[ready_num] == ST_IDLE);
        done_ok        = done_en && done_in_range && (state[done_num] == ST_BUSY);
    end

    // Next scan position: step the core field, flip the sequence bit on core wrap
    always_comb begin
        ptr_next = ptr;
        if (ptr[NUM_W-1:1] == CORE_LAST) begin
            ptr_next = {{CORE_W{1'b0}}, ~ptr[0]};
        end else begin
            ptr_next = {ptr[NUM_W-1:1] + 1'b1, ptr[0]};
        end
    end

    // Thread states, scan pointer, issue slot, READY count and sticky error
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < N_THREADS; i++) begin
                state[i] <= ST_IDLE;
            end
            ptr       <= '0;
            out_valid <= 1'b0;
            out_num   <= '0;
            ready_cnt <= '0;
            err       <= 1'b0;
        end else begin
            // ready_ok needs IDLE, done_ok needs BUSY, issue needs READY: never the same thread
            for (int i = 0; i < N_THREADS; i++) begin
                if (issue && ptr == NUM_W'(i)) begin
                    state[i] <= ST_BUSY;
                end
                if (ready_ok && ready_num == NUM_W'(i)) begin
                    state[i] <= ST_READY;
                end
                if (done_ok && done_num == NUM_W'(i)) begin
                    state[i] <= ST_IDLE;
                end
            end

            if (slot_free) begin
                ptr <= ptr_next;
                if (issue) begin
                    out_num   <= ptr;
                    out_valid <= 1'b1;
                end else if (out_rd) begin
                    out_valid <= 1'b0;
                end
            end

            case ({ready_ok, issue})
                2'b10:   ready_cnt <= ready_cnt + 1'b1;
                2'b01:   ready_cnt <= ready_cnt - 1'b1;
                default: ready_cnt <= ready_cnt;
            endcase

            if ((ready_en && !ready_ok) || (done_en && !done_ok)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
